// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one word per frame.
// Hits are served combinationally in IDLE. A miss starts a single
// outstanding fill that always completes to the address latched at the
// miss. Hit and miss counters saturate and are kept for the halt dump.
module icache #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  // datapath fetch side
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        halt,
  // memory controller instruction port
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  // performance counters
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t             r_state, w_next;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];
  logic [29:0]        r_fill_addr;   // {tag, idx} of the outstanding fill
  logic [31:0]        r_hit_count;
  logic [31:0]        r_miss_count;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_hit;
  logic               w_miss_start;
  logic               w_fill_done;
  logic               w_unused_bits;

  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_fill_addr[IDX_W-1:0];
  assign w_fill_tag = r_fill_addr[29:IDX_W];

  // Byte offset of the fetch address carries no information for a word cache.
  assign w_unused_bits = ^imemaddr[1:0];

  // Next-state and event decode; hits only in IDLE, fills end on !iwait.
  always_comb begin
    w_next       = r_state;
    w_hit        = 1'b0;
    w_miss_start = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (nRST && imemREN) begin
          if (r_valid[w_idx] && (r_tag[w_idx] == w_tag)) begin
            w_hit = 1'b1;
          end else if (!halt) begin
            w_miss_start = 1'b1;
            w_next       = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (nRST && !iwait) begin
          w_fill_done = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ihit       = w_hit;
  assign imemload   = w_hit ? r_data[w_idx] : 32'h0;
  assign iREN       = nRST && (r_state == S_FILL);
  assign iaddr      = iREN ? {r_fill_addr, 2'b00} : 32'h0;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Control state: FSM, valid bits, fill address; reset abandons any fill.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_fill_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss_start) begin
        r_fill_addr <= {w_tag, w_idx};
      end
      if (w_fill_done) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data store; fill_done is already qualified by nRST.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

  // Saturating hit/miss counters: a miss counts when its fill starts.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_start && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch side of `datapath_cache_if` and the memory controller's instruction port. Serves `imemREN`/`imemaddr` from a 16-frame, one-word-per-frame store. Returns `ihit` in the same cycle on a hit. On a miss, runs a single-outstanding fill FSM against memory. Keeps hit and miss counters for the performance dump at halt.

## Interface
Parameters:
- `SETS`, 16: number of frames; power of two, 2..256.
- `IDX_W`, $clog2(SETS): index width; derived, never overridden.

Ports:
- `CLK`: in, 1. Single clock; all state updates on the rising edge.
- `nRST`: in, 1. Reset, synchronous and active-low.
- `imemREN`: in, 1. Fetch request from the datapath.
- `imemaddr`: in, 32. Fetch byte address; bits [1:0] ignored.
- `ihit`: out, 1. Request served this cycle.
- `imemload`: out, 32. Instruction word; valid only while `ihit` = 1, otherwise 0.
- `halt`: in, 1. Datapath halted; no new fills start.
- `iREN`: out, 1. Read request to the memory controller.
- `iaddr`: out, 32. Word-aligned fill address to memory.
- `iload`: in, 32. Memory read data.
- `iwait`: in, 1. Memory busy; data is valid in a cycle with `iREN`=1 and `iwait`=0.
- `hit_count`: out, 32. Saturating count of hit cycles.
- `miss_count`: out, 32. Saturating count of fills started.

## Operation
- Address split:
  - index = `imemaddr[IDX_W+1:2]`
  - tag = `imemaddr[31:IDX_W+2]` (26 bits at SETS = 16)
- Storage per frame: `valid`, `tag`, `data[31:0]`.
- FSM states: IDLE, FILL.
- IDLE:
  - Hit = `imemREN` && `valid[idx]` && tag match && `nRST`.
  - On a hit: `ihit` = 1 and `imemload` = `data[idx]`, both combinational. `hit_count` increments.
  - On a miss with `!halt`: latch `{tag, idx}` into `fill_addr` and go to FILL. `miss_count` increments on that edge.
  - A miss while `halt` = 1 stays in IDLE with no memory traffic.
- FILL:
  - `iREN` = 1 and `iaddr` = `{fill_addr, 2'b00}`; `ihit` = 0.
  - On the edge where `iwait` = 0: write `iload`, tag and valid into frame `fill_addr.idx`, then return to IDLE.
  - The fill always completes to the latched address, even if `imemaddr` or `imemREN` changes mid-fill (squash or redirect). The new address is evaluated in IDLE afterwards.
  - `halt` does not abort a fill in progress.
- Replacement: direct-mapped, so a fill overwrites the frame unconditionally. There is no write path; the cache is never dirty.
- Counters saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- Hit latency: 0 cycles (same cycle as the request).
- Miss penalty:
  - FILL lasts N+1 cycles, where N is the number of `iwait`=1 cycles.
  - The hit is seen on the cycle after the fill edge.
  - Total from the request to `ihit` is N+2 cycles (2 cycles when `iwait` is low on the first FILL cycle).
- `iREN` rises on the cycle after the miss is detected. It falls on the cycle after the fill edge.
- Reset, on any edge with `nRST` = 0:
  - State goes to IDLE; all `valid` bits clear; `fill_addr` = 0; both counters = 0.
  - While `nRST` = 0, `ihit`, `iREN`, `iaddr` and `imemload` are all 0.
  - Reset mid-FILL abandons the fill; no frame is written.
- Simultaneous events:
  - Fill edge plus a new request to the same frame: the hit occurs the next cycle, never the same cycle.
  - Hit and `halt` in the same cycle: the hit is still served and counted.
- `iwait` held high forever: FILL persists. No timeout.

## Test plan
- **Reset:** hold `nRST`=0 for 2 cycles with `imemREN`=1 and `imemaddr`=0x0 → `ihit`=0, `iREN`=0, both counters 0. First cycle after release → `iREN`=0 (miss detected), then `iREN`=1 with `iaddr`=0x0.
- **Cold miss then hit:**
  - Stimulus: request 0x4; memory holds `iwait`=1 for 2 cycles, then `iload`=0x2008_0001.
  - Response: `ihit` first asserts 4 cycles after the request, with `imemload`=0x2008_0001. Then `miss_count`=1, `hit_count` increments per hit cycle.
- **Conflict eviction:** fill 0x0 (0xAAAA_0000), then 0x40 (0xBBBB_0040), then 0x0 again → three misses (`miss_count`=3); final `imemload`=0xAAAA_0000. Address 0x4 stays a hit throughout.
- **Redirect mid-fill:** miss on 0x10; change `imemaddr` to 0x80 during the `iwait` cycles → frame 4 is filled with tag 0. A new FILL then starts with `iaddr`=0x80; no `ihit` for 0x80 before that fill completes.
- **Reset mid-fill:** miss on 0x8; assert `nRST`=0 on the 2nd FILL cycle with `iwait`=1 → `iREN`=0 during reset. After release, 0x8 misses again; `miss_count` counts from 0.
- **Halt:** `halt`=1 with a miss on 0xC → `iREN` stays 0 for 10 cycles and `miss_count` is unchanged. A hit on a resident address still returns `ihit`=1.
